nx_stream_arbiter_rr: RTL and testbench
=======================================

# nx_stream_arbiter_rr

Parametrised N-channel round-robin stream arbiter with packet locking and a registered, decoupled output. It merges `CHANNELS` inbound valid/ready message streams into one outbound stream tagged with the source index. It holds a grant across multi-beat packets delimited by `last`, and breaks the combinational ready path with a 2-entry output buffer. It sits in front of the node decoder wherever more than four inbound links, or multi-beat messages, must share one consumer.

## Interface
- `STREAM_WIDTH`, 32: width of one data beat.
- `CHANNELS`, 4: number of inbound streams, legal range 2..16. Local `DIR_W` = $clog2(`CHANNELS`).
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `in_data_i` in `CHANNELS`*`STREAM_WIDTH`: packed beats; channel c occupies bits [c*`STREAM_WIDTH` +: `STREAM_WIDTH`].
- `in_last_i` in `CHANNELS`: final beat of a packet, per channel.
- `in_valid_i` in `CHANNELS`: beat valid, per channel.
- `in_ready_o` out `CHANNELS`: beat accepted, per channel; at most one bit high.
- `enable_i` in `CHANNELS`: channel is eligible for new grants.
- `arb_data_o` out `STREAM_WIDTH`: outbound beat.
- `arb_dir_o` out `DIR_W`: source channel index of the outbound beat.
- `arb_last_o` out 1: outbound last flag.
- `arb_valid_o` out 1: outbound valid.
- `arb_ready_i` in 1: outbound ready.

## Operation
- **State:**
  - `rr_ptr` (`DIR_W`): last channel to complete a packet. Reset value `CHANNELS`-1, so channel 0 has first priority.
  - `locked` (1): a packet is in progress. Reset value 0.
  - `lock_ch` (`DIR_W`): channel holding the lock. Reset value 0.
  - 2-entry FIFO of {data, dir, last} with count 0..2. Reset: empty.
- **Grant (combinational):**
  - When `locked`=1: grant = `lock_ch` if its `in_valid_i` is high; otherwise there is no grant. `enable_i` is ignored while locked, so a packet always completes.
  - When `locked`=0: search c = `rr_ptr`+1, +2, … modulo `CHANNELS`, wrapping at `CHANNELS`, not at 2^`DIR_W`. The first c with `in_valid_i`[c] & `enable_i`[c] is granted.
- **Ready:** `in_ready_o`[g] = grant found & FIFO count < 2. All other bits are 0. While `rst_i` is high, all bits are 0.
- **Accept:** a beat is accepted when `in_valid_i`[g] & `in_ready_o`[g]. It is pushed as {data, g, `in_last_i`[g]}.
  - Accepted beat with last=0: `locked` ← 1, `lock_ch` ← g.
  - Accepted beat with last=1: `locked` ← 0, `rr_ptr` ← g.
  - The pointer advances only on packet completion.
- **Output:**
  - `arb_valid_o` = count > 0.
  - `arb_data_o`, `arb_dir_o` and `arb_last_o` come from the FIFO head.
  - Pop on `arb_valid_o` & `arb_ready_i`.
  - Push and pop in the same cycle leave count unchanged.
- **Upstream protocol:** sources hold valid and data stable until accepted. Dropping valid mid-packet stalls the lock; it does not release it.

## Timing
- **Reset values:** `arb_valid_o`=0, `arb_data_o`=0, `arb_dir_o`=0, `arb_last_o`=0, `in_ready_o`=0.
- **Latency:** an input accepted in cycle N is visible on the output in cycle N+1.
- **Throughput:** sustained 1 beat/cycle when `arb_ready_i` is held high.
- **Decoupling:** `in_ready_o` does not depend combinationally on `arb_ready_i`. When count=2, inputs stall for one cycle after the first pop.
- **Full buffer:** count=2 with `arb_ready_i`=0 holds all `in_ready_o` low, and state is unchanged.
- **Empty buffer:** count=0 with no grant leaves `arb_valid_o`=0.
- **Single-beat packets (last=1 always):** behave as plain round-robin, one beat per grant.
- **Enable changes:** clearing `enable_i`[c] while c is locked has no effect until c's last beat is accepted.
- **Reset mid-packet:** the lock is dropped and buffered beats are discarded, with no partial-packet recovery.

## Test plan
- **Fairness:** `CHANNELS`=4, all valid, last=1, `arb_ready_i`=1. Required `arb_dir_o` sequence 0,1,2,3,0,… with one beat per cycle after the first output in cycle 1.
- **Packet lock:** ch1 sends 3 beats (last on beat 3) while ch0 and ch2 stay valid. Required output dir 1,1,1, then 2, then 0. No interleaving occurs.
- **Backpressure:** `arb_ready_i`=0 for 5 cycles with ch3 streaming. Required: exactly 2 beats accepted, `in_ready_o`=0 thereafter. After release, data order is preserved with no loss or duplicate.
- **Enable mask:** `enable_i`=4'b1010, all valid. Required dir sequence 1,3,1,3. Clearing `enable_i`[1] mid-packet lets ch1 finish its packet, then ch1 receives no further grants.
- **Non-power-of-two width:** `CHANNELS`=5, `rr_ptr`=4, only ch0 valid. Required grant 0; the search never evaluates index 5-7.
- **Reset mid-packet:** assert `rst_i` asynchronously with count=2 and locked on ch2. Required: `arb_valid_o`=0 immediately. After release, ch0 is served first.

Source files
------------

// File: rtl/nx_stream_arbiter_rr_if.sv
// Stream bundle for nx_stream_arbiter_rr: CHANNELS inbound valid/ready lanes
// plus one outbound lane tagged with its source channel.
interface nx_stream_arbiter_rr_if #(
  parameter int STREAM_WIDTH = 32,
  parameter int CHANNELS     = 4
);
  localparam int DIR_W = $clog2(CHANNELS);

  logic [CHANNELS*STREAM_WIDTH-1:0] in_data_i;
  logic [CHANNELS-1:0]              in_last_i;
  logic [CHANNELS-1:0]              in_valid_i;
  logic [CHANNELS-1:0]              in_ready_o;
  logic [CHANNELS-1:0]              enable_i;
  logic [STREAM_WIDTH-1:0]          arb_data_o;
  logic [DIR_W-1:0]                 arb_dir_o;
  logic                             arb_last_o;
  logic                             arb_valid_o;
  logic                             arb_ready_i;

  modport slave (
    input  in_data_i, in_last_i, in_valid_i, enable_i, arb_ready_i,
    output in_ready_o, arb_data_o, arb_dir_o, arb_last_o, arb_valid_o
  );

  modport master (
    output in_data_i, in_last_i, in_valid_i, enable_i, arb_ready_i,
    input  in_ready_o, arb_data_o, arb_dir_o, arb_last_o, arb_valid_o
  );
endinterface

// File: rtl/nx_stream_arbiter_rr.sv
// Round-robin N:1 stream arbiter that holds its grant for a whole packet and
// feeds a 2-entry output buffer, so in_ready_o never sees arb_ready_i.
module nx_stream_arbiter_rr #(
  parameter int STREAM_WIDTH = 32,
  parameter int CHANNELS     = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  nx_stream_arbiter_rr_if.slave bus
);
  localparam int DIR_W = $clog2(CHANNELS);

  typedef logic [DIR_W-1:0] dir_t;

  typedef struct packed {
    logic [STREAM_WIDTH-1:0] data;
    dir_t                    dir;
    logic                    last;
  } beat_t;

  dir_t       r_rr_ptr;
  dir_t       r_lock_ch;
  logic       r_locked;
  beat_t      r_fifo [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic  w_found;
  dir_t  w_grant;
  dir_t  w_cand;
  logic  w_full;
  logic  w_push;
  logic  w_pop;
  beat_t w_beat;

  // Wraps at CHANNELS rather than 2^DIR_W so unused indices are never searched.
  function automatic dir_t wrap_add(input dir_t base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    return dir_t'(sum);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    if (r_locked) begin
      w_found = bus.in_valid_i[r_lock_ch];
      w_grant = r_lock_ch;
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        w_cand = wrap_add(r_rr_ptr, k);
        if (!w_found && bus.in_valid_i[w_cand] && bus.enable_i[w_cand]) begin
          w_found = 1'b1;
          w_grant = w_cand;
        end
      end
    end
  end

  assign w_full = (r_count == 2'd2);
  assign w_push = w_found && !w_full && !rst_i;
  assign w_pop  = (r_count != 2'd0) && bus.arb_ready_i;

  always_comb begin
    bus.in_ready_o = '0;
    if (w_push) bus.in_ready_o[w_grant] = 1'b1;
  end

  always_comb begin
    w_beat.data = bus.in_data_i[int'(w_grant)*STREAM_WIDTH +: STREAM_WIDTH];
    w_beat.dir  = w_grant;
    w_beat.last = bus.in_last_i[w_grant];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr  <= dir_t'(CHANNELS - 1);
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      // NOTE: the buffer storage is reset because its head drives arb_data_o directly and must read zero out of reset.
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments so each register takes pre-edge values regardless of statement order.
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_beat;
        r_wr_ptr         <= ~r_wr_ptr;
        if (w_beat.last) begin
          r_locked <= 1'b0;
          r_rr_ptr <= w_grant;
        end else begin
          r_locked  <= 1'b1;
          r_lock_ch <= w_grant;
        end
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (!w_push && w_pop) r_count <= r_count - 2'd1;
    end
  end

  assign bus.arb_valid_o = (r_count != 2'd0);
  assign bus.arb_data_o  = r_fifo[r_rd_ptr].data;
  assign bus.arb_dir_o   = r_fifo[r_rd_ptr].dir;
  assign bus.arb_last_o  = r_fifo[r_rd_ptr].last;

endmodule

// File: tb/tb_nx_stream_arbiter_rr.sv
// Bench for nx_stream_arbiter_rr: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_nx_stream_arbiter_rr;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nx_stream_arbiter_rr_if #(.STREAM_WIDTH(W), .CHANNELS(4)) bus4 ();
  nx_stream_arbiter_rr_if #(.STREAM_WIDTH(W), .CHANNELS(5)) bus5 ();

  nx_stream_arbiter_rr #(.STREAM_WIDTH(W), .CHANNELS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(bus4.slave));
  nx_stream_arbiter_rr #(.STREAM_WIDTH(W), .CHANNELS(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .bus(bus5.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst_before;
    logic [3:0] valid;
    logic [3:0] enable;
    logic [3:0] last;
    logic       ardy;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_dir;
    logic       exp_last;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input bit r, input logic [3:0] v, input logic [3:0] e,
                              input logic [3:0] l, input logic a, input logic [3:0] er,
                              input logic ev, input logic [1:0] ed, input logic el);
    vec_t x;
    x.rst_before = r; x.valid = v; x.enable = e; x.last = l; x.ardy = a;
    x.exp_ready = er; x.exp_valid = ev; x.exp_dir = ed; x.exp_last = el;
    return x;
  endfunction

  task automatic set_idle();
    bus4.in_valid_i = '0; bus4.in_last_i = '0; bus4.enable_i = '0; bus4.arb_ready_i = 1'b0;
    bus5.in_valid_i = '0; bus5.in_last_i = '0; bus5.enable_i = '0; bus5.arb_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus4.in_valid_i = '1; bus4.enable_i = '1; bus4.in_last_i = '1; bus4.arb_ready_i = 1'b1;
    #1;
    check("rst_in_ready", bus4.in_ready_o, 0);
    check("rst_arb_valid", bus4.arb_valid_o, 0);
    check("rst_arb_data", bus4.arb_data_o, 0);
    check("rst_arb_dir", bus4.arb_dir_o, 0);
    check("rst_arb_last", bus4.arb_last_o, 0);
    @(negedge clk);
    rst = 1'b0;
    set_idle();
  endtask

  // Reference model: output buffer as a queue, arbitration from the textual rules.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  dir;
    logic        last;
  } mbeat_t;

  mbeat_t mq[$];
  int     m_rr;
  bit     m_locked;
  int     m_lock;

  function automatic int model_grant(input logic [3:0] v, input logic [3:0] en);
    if (m_locked) return v[m_lock] ? m_lock : -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_rr + k) % 4;
      if (v[c] && en[c]) return c;
    end
    return -1;
  endfunction

  task automatic np_step(input string name, input logic [4:0] v, input logic [4:0] exp_rdy,
                         input bit chk_dir, input logic [2:0] exp_dir);
    @(negedge clk);
    bus5.in_valid_i = v;
    #1;
    check({name, "_ready"}, bus5.in_ready_o, exp_rdy);
    if (chk_dir) check({name, "_dir"}, bus5.arb_dir_o, exp_dir);
  endtask

  logic [31:0] bp_sent[$];
  logic [31:0] bp_got[$];
  logic [31:0] bp_seq;
  int          bp_acc;

  logic [3:0]  sv, sl, sen;
  logic [31:0] sd [4];
  int          g;
  logic [3:0]  erdy;
  bit          ardy;
  mbeat_t      nb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_idle();
    for (int c = 0; c < 4; c++) bus4.in_data_i[c*W +: W] = 32'hA000_0000 + c;
    for (int c = 0; c < 5; c++) bus5.in_data_i[c*W +: W] = 32'hB000_0000 + c;

    // Fairness: plain round robin, one beat per cycle
    vecs[0]  = mk(1, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0);
    vecs[1]  = mk(0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 1);
    vecs[2]  = mk(0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0100, 1, 1, 1);
    vecs[3]  = mk(0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b1000, 1, 2, 1);
    vecs[4]  = mk(0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0001, 1, 3, 1);
    vecs[5]  = mk(0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 1);
    // Packet lock: ch0 primes rr_ptr, then ch1 sends 3 beats while ch0/ch2 wait
    vecs[6]  = mk(1, 4'b0001, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0);
    vecs[7]  = mk(0, 4'b0111, 4'b1111, 4'b1101, 1, 4'b0010, 1, 0, 1);
    vecs[8]  = mk(0, 4'b0111, 4'b1111, 4'b1101, 1, 4'b0010, 1, 1, 0);
    vecs[9]  = mk(0, 4'b0111, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 0);
    vecs[10] = mk(0, 4'b0101, 4'b1111, 4'b1111, 1, 4'b0100, 1, 1, 1);
    vecs[11] = mk(0, 4'b0001, 4'b1111, 4'b1111, 1, 4'b0001, 1, 2, 1);
    vecs[12] = mk(0, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0000, 1, 0, 1);
    vecs[13] = mk(0, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0);
    // Enable mask 1010
    vecs[14] = mk(1, 4'b1111, 4'b1010, 4'b1111, 1, 4'b0010, 0, 0, 0);
    vecs[15] = mk(0, 4'b1111, 4'b1010, 4'b1111, 1, 4'b1000, 1, 1, 1);
    vecs[16] = mk(0, 4'b1111, 4'b1010, 4'b1111, 1, 4'b0010, 1, 3, 1);
    vecs[17] = mk(0, 4'b1111, 4'b1010, 4'b1111, 1, 4'b1000, 1, 1, 1);
    vecs[18] = mk(0, 4'b0000, 4'b1010, 4'b1111, 1, 4'b0000, 1, 3, 1);
    // Clearing enable[1] mid-packet: ch1 finishes, then never granted again
    vecs[19] = mk(1, 4'b0010, 4'b1010, 4'b1101, 1, 4'b0010, 0, 0, 0);
    vecs[20] = mk(0, 4'b1010, 4'b1000, 4'b1101, 1, 4'b0010, 1, 1, 0);
    vecs[21] = mk(0, 4'b1010, 4'b1000, 4'b1111, 1, 4'b0010, 1, 1, 0);
    vecs[22] = mk(0, 4'b1010, 4'b1000, 4'b1111, 1, 4'b1000, 1, 1, 1);
    vecs[23] = mk(0, 4'b1010, 4'b1000, 4'b1111, 1, 4'b1000, 1, 3, 1);
    vecs[24] = mk(0, 4'b1010, 4'b1000, 4'b1111, 1, 4'b1000, 1, 3, 1);
    // Full buffer: ready stays low one cycle after the first pop
    vecs[25] = mk(1, 4'b0001, 4'b1111, 4'b1111, 0, 4'b0001, 0, 0, 0);
    vecs[26] = mk(0, 4'b0001, 4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 1);
    vecs[27] = mk(0, 4'b0001, 4'b1111, 4'b1111, 0, 4'b0000, 1, 0, 1);
    vecs[28] = mk(0, 4'b0001, 4'b1111, 4'b1111, 1, 4'b0000, 1, 0, 1);
    vecs[29] = mk(0, 4'b0001, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0, 1);

    for (int i = 0; i < 30; i++) begin
      if (vecs[i].rst_before) do_reset();
      @(negedge clk);
      bus4.in_valid_i  = vecs[i].valid;
      bus4.enable_i    = vecs[i].enable;
      bus4.in_last_i   = vecs[i].last;
      bus4.arb_ready_i = vecs[i].ardy;
      #1;
      check($sformatf("vec%0d_ready", i), bus4.in_ready_o, vecs[i].exp_ready);
      check($sformatf("vec%0d_valid", i), bus4.arb_valid_o, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_dir", i), bus4.arb_dir_o, vecs[i].exp_dir);
        check($sformatf("vec%0d_last", i), bus4.arb_last_o, vecs[i].exp_last);
        check($sformatf("vec%0d_data", i), bus4.arb_data_o, 32'hA000_0000 + 32'(vecs[i].exp_dir));
      end
    end

    // Backpressure: ch3 streams while the consumer stalls for 5 cycles
    do_reset();
    bp_seq = 32'h5000_0000;
    bp_acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus4.enable_i = '1; bus4.in_last_i = '1; bus4.in_valid_i = 4'b1000; bus4.arb_ready_i = 1'b0;
      bus4.in_data_i[3*W +: W] = bp_seq;
      #1;
      if (i >= 2) check($sformatf("bp_stall%0d_ready", i), bus4.in_ready_o, 0);
      if (bus4.in_ready_o[3]) begin
        bp_sent.push_back(bp_seq);
        bp_seq++;
        bp_acc++;
      end
    end
    check("bp_accepted_count", bp_acc, 2);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus4.arb_ready_i = 1'b1;
      bus4.in_valid_i  = (i < 6) ? 4'b1000 : 4'b0000;
      bus4.in_data_i[3*W +: W] = bp_seq;
      #1;
      if (i == 0) check("bp_release_ready", bus4.in_ready_o, 0);
      if (bus4.arb_valid_o) bp_got.push_back(bus4.arb_data_o);
      if (bus4.in_ready_o[3]) begin
        bp_sent.push_back(bp_seq);
        bp_seq++;
      end
    end
    check("bp_beat_count", bp_got.size(), bp_sent.size());
    for (int i = 0; i < bp_sent.size() && i < bp_got.size(); i++)
      check($sformatf("bp_order%0d", i), bp_got[i], bp_sent[i]);
    set_idle();

    // CHANNELS=5: wrap at 5, never at 8
    do_reset();
    bus5.enable_i = '1; bus5.in_last_i = '1; bus5.arb_ready_i = 1'b1;
    np_step("np_ch4", 5'b10000, 5'b10000, 0, 0);
    np_step("np_wrap0", 5'b00001, 5'b00001, 1, 3'd4);
    np_step("np_ch4_again", 5'b10001, 5'b10000, 1, 3'd0);
    np_step("np_wrap1", 5'b10001, 5'b00001, 1, 3'd4);
    set_idle();

    // Reset mid-packet: buffer full, locked on ch2
    do_reset();
    bus4.enable_i = '1; bus4.in_last_i = 4'b1011; bus4.arb_ready_i = 1'b0;
    @(negedge clk);
    bus4.in_valid_i = 4'b0100;
    #1;
    check("rmp_first_ready", bus4.in_ready_o, 4'b0100);
    @(negedge clk);
    #1;
    check("rmp_second_ready", bus4.in_ready_o, 4'b0100);
    @(negedge clk);
    #1;
    check("rmp_full_ready", bus4.in_ready_o, 0);
    check("rmp_full_valid", bus4.arb_valid_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rmp_async_valid", bus4.arb_valid_o, 0);
    check("rmp_async_ready", bus4.in_ready_o, 0);
    @(negedge clk);
    rst = 1'b0;
    bus4.in_valid_i = '1; bus4.in_last_i = '1; bus4.arb_ready_i = 1'b1;
    #1;
    check("rmp_after_ready", bus4.in_ready_o, 4'b0001);
    @(negedge clk);
    #1;
    check("rmp_after_dir", bus4.arb_dir_o, 0);
    check("rmp_after_valid", bus4.arb_valid_o, 1);
    set_idle();

    // Randomized run against the reference model
    do_reset();
    m_rr = 3; m_locked = 0; m_lock = 0; mq.delete();
    sv = '0; sl = '0; sen = '1;
    for (int c = 0; c < 4; c++) sd[c] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (!sv[c] && $urandom_range(0, 2) != 0) begin
          sv[c] = 1'b1;
          sd[c] = $urandom;
          sl[c] = ($urandom_range(0, 2) == 0);
        end
      end
      if ($urandom_range(0, 15) == 0) sen = 4'($urandom);
      ardy = ($urandom_range(0, 3) != 0);
      bus4.in_valid_i  = sv;
      bus4.in_last_i   = sl;
      bus4.enable_i    = sen;
      bus4.arb_ready_i = ardy;
      for (int c = 0; c < 4; c++) bus4.in_data_i[c*W +: W] = sd[c];
      #1;
      g    = model_grant(sv, sen);
      erdy = (g >= 0 && mq.size() < 2) ? 4'(1 << g) : 4'b0000;
      check("rand_ready", bus4.in_ready_o, erdy);
      check("rand_valid", bus4.arb_valid_o, mq.size() > 0);
      if (mq.size() > 0) begin
        check("rand_data", bus4.arb_data_o, mq[0].data);
        check("rand_dir", bus4.arb_dir_o, mq[0].dir);
        check("rand_last", bus4.arb_last_o, mq[0].last);
      end
      @(posedge clk);
      if (mq.size() > 0 && ardy) void'(mq.pop_front());
      if (erdy != 4'b0000) begin
        nb.data = sd[g];
        nb.dir  = 2'(g);
        nb.last = sl[g];
        mq.push_back(nb);
        if (sl[g]) begin
          m_locked = 0;
          m_rr     = g;
        end else begin
          m_locked = 1;
          m_lock   = g;
        end
        sv[g] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
